ram_sp_master: RTL and testbench

- Request-side controller for the team's single-port RAM (`ram_sp`). It accepts read/write commands on a valid/ready channel and drives the RAM's en/we/addr/din pins.
- It collects read data on the RAM's dout/dout_valid pins and returns it on a valid/ready response channel.
- The RAM read pipeline cannot stall, so reads are issued only against reserved response-FIFO credits. Read data is never lost under response backpressure.
- Sits between any client (DMA, packet buffer logic) and one ram_sp instance.

---
 rtl/ram_sp_master_pkg.sv | 15 +
 rtl/ram_sp_master_if.sv | 28 ++
 rtl/ram_sp_master_rsp_fifo.sv | 71 +++++++
 rtl/ram_sp_master.sv | 168 ++++++++++++++++
 tb/tb_ram_sp_master.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_sp_master_pkg.sv
// Shared definitions for the ram_sp request-side controller: FSM state
// encoding and the width helper used for credit/occupancy counters.
package ram_sp_master_pkg;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Width of a counter that must hold every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ram_sp_master_if.sv
// Client-side command/response channel of ram_sp_master.
// master: the client issuing commands; slave: the controller.
interface ram_sp_master_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 14
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_sp_master_rsp_fifo.sv
// rsp_fifo: synchronous FIFO whose head entry is read straight out of the
// storage registers. A push is visible one cycle later; push and pop in the
// same cycle are legal whether the FIFO is empty or full.
module rsp_fifo
  import ram_sp_master_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap because DEPTH is a power of two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ram_sp_master.sv
// ram_sp_master: request-side controller for one ram_sp instance.
// Commands arrive on a valid/ready channel and are issued to the RAM one cycle
// after acceptance. Reads are issued only against reserved response-FIFO
// credits, so the non-stallable RAM read pipeline can never overflow the FIFO.
// After reset a FLUSH phase ignores ram_dout_valid while stale reads drain.
// Optional build macro RAM_SP_MASTER_LAT_CHECK_EN adds a read-latency tracker
// driving the sticky lat_err flag; without it lat_err is tied low.
module ram_sp_master
  import ram_sp_master_pkg::*;
#(
  parameter int DATA_WIDTH     = 36,
  parameter int ADDR_WIDTH     = 14,
  parameter int RD_LATENCY     = 5,
  parameter int RSP_FIFO_DEPTH = 8,
  parameter int FLUSH_CYCLES   = RD_LATENCY + 2
) (
  input  logic                                clk,
  input  logic                                rst,
  ram_sp_master_if.slave                      req_if,
  output logic                                ram_en,
  output logic                                ram_we,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic [DATA_WIDTH-1:0]               ram_din,
  input  logic [DATA_WIDTH-1:0]               ram_dout,
  input  logic                                ram_dout_valid,
  output logic [cnt_width(RSP_FIFO_DEPTH)-1:0] outstanding,
  output logic                                lat_err
);

  localparam int CW = cnt_width(RSP_FIFO_DEPTH);
  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam logic [CW-1:0] DEPTH_C    = CW'(RSP_FIFO_DEPTH);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

  logic in_run, accept, rd_accept, rsp_pop, rsp_push;
  logic fifo_full, fifo_empty;

  // Handshake qualifiers. Writes are also held off at zero credits.
  assign in_run           = (state_q == ST_RUN);
  assign req_if.req_ready = in_run && (credits_q != '0);
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign rd_accept        = accept && !req_if.req_we;
  assign rsp_pop          = req_if.rsp_valid && req_if.rsp_ready;
  assign rsp_push         = in_run && ram_dout_valid;

  // FLUSH counts FLUSH_CYCLES cycles, then RUN holds until the next reset.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) state_d = ST_RUN;
        else                           flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // Credits: one reserved per accepted read, returned per response pop.
  always_comb begin
    credits_d = credits_q;
    case ({rd_accept, rsp_pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // Issue stage: an accepted command drives the RAM pins for exactly one cycle.
  always_comb begin
    ram_en_d   = accept;
    ram_we_d   = accept && req_if.req_we;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (accept) begin
      ram_addr_d = req_if.req_addr;
      ram_din_d  = req_if.req_wdata;
    end
  end

  // Controller registers; reset discards in-flight reads and restarts FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      credits_q   <= DEPTH_C;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      credits_q   <= credits_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign outstanding = DEPTH_C - credits_q;

  rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (ram_dout),
    .pop       (req_if.rsp_ready),
    .pop_data  (req_if.rsp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign req_if.rsp_valid = !fifo_empty;

  // Credit construction guarantees room for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_push && fifo_full && !req_if.rsp_ready));

`ifdef RAM_SP_MASTER_LAT_CHECK_EN
  logic [RD_LATENCY-1:0] trk_q, trk_d;
  logic                  lat_err_q, lat_err_d;
  logic                  rd_issue;

  assign rd_issue = ram_en_q && !ram_we_q;

  // Tracker predicts dout_valid RD_LATENCY cycles after each issued read.
  always_comb begin
    trk_d     = (trk_q << 1) | RD_LATENCY'(rd_issue);
    lat_err_d = lat_err_q || (in_run && (ram_dout_valid != trk_q[RD_LATENCY-1]));
  end

  // Tracker and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q     <= '0;
      lat_err_q <= 1'b0;
    end else begin
      trk_q     <= trk_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign lat_err = lat_err_q;
`else
  assign lat_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_master.sv
// Self-checking bench for ram_sp_master. A transaction-level reference model
// (expected-response queue with ready times, credit count, shadow memory)
// predicts every output; a behavioural RAM with configurable latency feeds
// the read-data pins. Directed steps are followed by a randomized phase.
module tb_ram_sp_master;

  localparam int DW    = 36;
  localparam int AW    = 14;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
`ifdef RAM_SP_MASTER_LAT_CHECK_EN
  localparam bit LAT_CHK = 1'b1;
`else
  localparam bit LAT_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          ram_dout_valid = 1'b0;
  logic [3:0]    outstanding;
  logic          lat_err;

  always #5 clk = ~clk;

  ram_sp_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_sp_master #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .RD_LATENCY     (LAT),
    .RSP_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_if         (bus),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_dout_valid (ram_dout_valid),
    .outstanding    (outstanding),
    .lat_err        (lat_err)
  );

  typedef struct { longint t;   logic [DW-1:0] d; } rsp_t;
  typedef struct { longint due; logic [DW-1:0] d; } pend_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural RAM and reference-model state.
  logic [DW-1:0] ram_mem [int];
  logic [DW-1:0] ref_mem [int];
  pend_t         pend_q [$];
  rsp_t          exp_q [$];
  longint        cyc = 0;
  longint        run_from = 64'h7fff_ffff;
  longint        lat_from = -1;
  int            ram_lat = LAT;
  int            out_cnt = 0;
  bit            checking = 1'b0;
  bit            stray = 1'b0;
  bit            last_ready, last_acc, last_pop;
  longint        last_pop_cyc, last_rd_cyc;
  logic [DW-1:0] last_pop_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {4'hA, 32'hC0DE_0000 ^ 32'(i)};
  endfunction

  // One clock cycle: drive RAM read data, compare outputs, advance the model.
  task automatic step();
    bit    exp_ready, exp_rv, exp_lat, acc, pop;
    pend_t p;
    rsp_t  r;
    #1;
    if (ram_en === 1'b1) begin
      if (ram_we) ram_mem[int'(ram_addr)] = ram_din;
      else begin
        p.due = cyc + ram_lat;
        p.d   = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : '0;
        pend_q.push_back(p);
      end
    end
    if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      ram_dout_valid = 1'b1;
      ram_dout       = pend_q[0].d;
      void'(pend_q.pop_front());
    end else begin
      ram_dout_valid = stray;
      ram_dout       = stray ? {4'h5, $urandom} : '0;
    end

    exp_ready = (cyc >= run_from) && (out_cnt < DEPTH);
    exp_rv    = (exp_q.size() != 0) && (exp_q[0].t <= cyc);
    exp_lat   = LAT_CHK && (lat_from >= 0) && (cyc >= lat_from);
    if (checking) begin
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
      if (exp_rv) check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q[0].d));
      check("outstanding", 64'(outstanding), 64'(out_cnt));
      check("lat_err", 64'(lat_err), 64'(exp_lat));
    end

    last_ready = bus.req_ready;
    acc = checking && bus.req_valid && exp_ready && !rst;
    pop = checking && exp_rv && bus.rsp_ready && !rst;
    last_acc = acc;
    last_pop = pop;
    if (pop) begin
      last_pop_data = exp_q[0].d;
      last_pop_cyc  = cyc;
      void'(exp_q.pop_front());
      out_cnt--;
    end
    if (acc) begin
      if (bus.req_we) ref_mem[int'(bus.req_addr)] = bus.req_wdata;
      else begin
        r.t = cyc + 2 + ram_lat;
        r.d = ref_mem.exists(int'(bus.req_addr)) ? ref_mem[int'(bus.req_addr)] : '0;
        exp_q.push_back(r);
        out_cnt++;
        last_rd_cyc = cyc;
        if (ram_lat != LAT && lat_from < 0) lat_from = cyc + 2 + LAT;
      end
    end
    if (rst) begin
      exp_q.delete();
      out_cnt  = 0;
      run_from = cyc + 8;
      lat_from = -1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) break;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_pop(output longint lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_pop) begin
        lat = last_pop_cyc - last_rd_cyc;
        break;
      end
    end
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && (out_cnt != 0 || pend_q.size() != 0); i++) step();
    check("drain_outstanding", 64'(outstanding), 64'(0));
  endtask

  task automatic reset_pulse();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_ready) break;
    end
  endtask

  initial begin
    int     lows, issued, rx, n;
    longint lat;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    checking = 1'b1;

    // Reset values and FLUSH length, with a stray dout_valid during FLUSH.
    check("rst_ram_en", 64'(ram_en), 64'(0));
    check("rst_ram_we", 64'(ram_we), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_ram_din", 64'(ram_din), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      stray = (i == 2);
      step();
      if (last_ready) break;
      lows++;
    end
    stray = 1'b0;
    check("flush_len", 64'(lows), 64'(LAT + 2));

    // Single write then read-back: pin timing and end-to-end latency.
    bus.rsp_ready = 1'b1;
    issue(1'b1, 14'h10, 36'h1_2345_6789);
    check("wr_ram_en", 64'(ram_en), 64'(1));
    check("wr_ram_we", 64'(ram_we), 64'(1));
    check("wr_ram_addr", 64'(ram_addr), 64'h10);
    check("wr_ram_din", 64'(ram_din), 64'h1_2345_6789);
    issue(1'b0, 14'h10, '0);
    check("rd_ram_en", 64'(ram_en), 64'(1));
    check("rd_ram_we", 64'(ram_we), 64'(0));
    step();
    check("idle_ram_en", 64'(ram_en), 64'(0));
    check("idle_ram_addr_hold", 64'(ram_addr), 64'h10);
    wait_pop(lat);
    check("rd_latency", 64'(lat), 64'(LAT + 2));
    check("rd_data", 64'(last_pop_data), 64'h1_2345_6789);

    // Fill 20 words, then read them under full backpressure.
    for (int i = 0; i < 20; i++) issue(1'b1, AW'(14'h100 + i), pat(i));
    drain();
    bus.rsp_ready = 1'b0;
    issued = 0;
    for (int i = 0; i < 30; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(14'h100 + issued);
      step();
      if (last_acc) issued++;
    end
    check("bp_accepted", 64'(issued), 64'(DEPTH));
    check("bp_req_ready", 64'(bus.req_ready), 64'(0));
    check("bp_outstanding", 64'(outstanding), 64'(DEPTH));
    bus.rsp_ready = 1'b1;
    rx = 0;
    for (int i = 0; i < 200 && rx < 20; i++) begin
      bus.req_valid = (issued < 20);
      bus.req_addr  = AW'(14'h100 + issued);
      step();
      if (last_acc) issued++;
      if (last_pop) rx++;
    end
    bus.req_valid = 1'b0;
    check("bp_returned", 64'(rx), 64'(20));
    check("bp_last_data", 64'(last_pop_data), 64'(pat(19)));

    // Steady state: one read per cycle with credits constant.
    drain();
    n = 0;
    for (int i = 0; i < 60; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(14'h100 + $urandom_range(0, 19));
      step();
      if (i >= 20 && last_acc) n++;
    end
    check("steady_rate", 64'(n), 64'(40));
    check("steady_outstanding", 64'(outstanding), 64'(LAT + 2));
    bus.req_valid = 1'b0;

    // Reset with four reads in flight; stale returns must be dropped.
    drain();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(14'h100 + i);
      step();
    end
    reset_pulse();
    check("rst_inflight_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_inflight_outstanding", 64'(outstanding), 64'(0));
    wait_run();
    issue(1'b0, 14'h10, '0);
    wait_pop(lat);
    check("post_rst_data", 64'(last_pop_data), 64'h1_2345_6789);

    // RAM latency one cycle longer than configured.
    drain();
    ram_lat = LAT + 1;
    issue(1'b0, 14'h10, '0);
    wait_pop(lat);
    check("slow_ram_data", 64'(last_pop_data), 64'h1_2345_6789);
    repeat (5) step();
    check("lat_err_sticky", 64'(lat_err), 64'(LAT_CHK));
    ram_lat = LAT;
    reset_pulse();
    check("lat_err_cleared", 64'(lat_err), 64'(0));
    wait_run();

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 20; i++) issue(1'b1, AW'(i), {4'h3, $urandom});
    for (int i = 0; i < 500; i++) begin
      if (!bus.req_valid || last_acc) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_we    = ($urandom_range(0, 3) == 0);
        bus.req_addr  = AW'($urandom_range(0, 31));
        bus.req_wdata = {4'($urandom), $urandom};
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
